// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - byte-laned load/store initiator for an 8192x32 synchronous RAM
//
// Accepts byte/halfword/word loads and stores at byte granularity. Accesses that
// cross a word boundary are split into two RAM cycles, and the two read words are
// merged. Loads are sign- or zero-extended.
//
// Optional feature macro: RAM_ACCESS_MISALIGN_TRAP_EN
//   defined   : crossing requests issue no RAM cycle and complete with err = 1
//   undefined : crossing requests are split; err is constant 0
//
// Ports:
//   clk, reset_b          clock, asynchronous active-low reset
//   req                   one-cycle request strobe (sampled in IDLE only)
//   we, size, sgn         store enable, 00/01/10(11) = byte/half/word, sign-extend
//   addr, wdata           byte address, right-justified store data
//   busy, ack, err        busy until ack inclusive, completion pulse, trap pulse
//   rdata                 load result, held until the next load ack
//   ram_address, ram_din  RAM word address and write data (registered)
//   ram_dout              RAM read data, valid the cycle after the read edge
//   ram_rnw, ram_cs_b     read/not-write, active-low byte lane selects
module ram_access_ctrl #(
  parameter int AW = 15,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          sgn,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic [AW-3:0] ram_address,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_rnw,
  output logic [3:0]    ram_cs_b
);

`ifdef RAM_ACCESS_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A1   = 3'd1,
    S_A2   = 3'd2,
    S_W    = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Captured request
  logic       cap_we;
  logic [1:0] cap_size;
  logic       cap_sgn;
  logic [1:0] cap_off;
  logic       cap_cross;
  logic       cap_trap;
  logic [3:0] cap_lanes2;
  logic [DW-1:0] word1;

  // Request decode, evaluated on the live inputs at the accept edge
  logic [3:0]    base_lanes;
  logic [7:0]    lanes_in;
  logic          cross_in;
  logic [DW-1:0] din_in;
  logic          accept;

  always_comb begin
    base_lanes = 4'b1111;
    case (size)
      2'b00:   base_lanes = 4'b0001;
      2'b01:   base_lanes = 4'b0011;
      default: base_lanes = 4'b1111;
    endcase
  end

  // Lanes 7:4 of the shifted mask are the lanes 3:0 of the following word
  assign lanes_in = {4'b0000, base_lanes} << addr[1:0];
  assign cross_in = |lanes_in[7:4];
  // Rotate left by 8*off: upper half of the doubled word shifted left
  assign din_in   = DW'(({wdata, wdata} << {addr[1:0], 3'b000}) >> DW);
  assign accept   = (state == S_IDLE) && req;

  // Load merge
  logic [63:0]   pair;
  logic [DW-1:0] shifted;
  logic [DW-1:0] load_val;

  always_comb begin
    pair     = cap_cross ? {ram_dout, word1} : {32'h0, ram_dout};
    shifted  = DW'(pair >> {cap_off, 3'b000});
    load_val = shifted;
    case (cap_size)
      2'b00:   load_val = {{24{cap_sgn & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{cap_sgn & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req) state_nxt = S_A1;
      S_A1: begin
        if (cap_trap)       state_nxt = S_DONE;
        else if (cap_cross) state_nxt = S_A2;
        else if (cap_we)    state_nxt = S_DONE;
        else                state_nxt = S_W;
      end
      S_A2:    state_nxt = cap_we ? S_DONE : S_W;
      S_W:     state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state != S_IDLE);
    ack  = (state == S_DONE);
    err  = (state == S_DONE) && cap_trap;
  end

  // Datapath and registered RAM port
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cap_we      <= 1'b0;
      cap_size    <= 2'b00;
      cap_sgn     <= 1'b0;
      cap_off     <= 2'b00;
      cap_cross   <= 1'b0;
      cap_trap    <= 1'b0;
      cap_lanes2  <= 4'h0;
      word1       <= '0;
      rdata       <= '0;
      ram_address <= '0;
      ram_din     <= '0;
      ram_rnw     <= 1'b1;
      ram_cs_b    <= 4'hF;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_we      <= we;
            cap_size    <= size;
            cap_sgn     <= sgn;
            cap_off     <= addr[1:0];
            cap_cross   <= cross_in;
            cap_trap    <= TRAP_EN && cross_in;
            cap_lanes2  <= lanes_in[7:4];
            ram_address <= addr[AW-1:2];
            ram_din     <= din_in;
            if (TRAP_EN && cross_in) begin
              ram_cs_b <= 4'hF;
              ram_rnw  <= 1'b1;
            end else begin
              ram_cs_b <= ~lanes_in[3:0];
              ram_rnw  <= ~we;
            end
          end
        end
        S_A1: begin
          if (cap_cross && !cap_trap) begin
            // Second word; 13-bit add wraps 8191 -> 0
            ram_address <= ram_address + 1'b1;
            ram_cs_b    <= ~cap_lanes2;
          end else begin
            ram_cs_b <= 4'hF;
            ram_rnw  <= 1'b1;
          end
        end
        S_A2: begin
          ram_cs_b <= 4'hF;
          ram_rnw  <= 1'b1;
          // Data for the A1 read is on ram_dout during A2
          if (!cap_we) word1 <= ram_dout;
        end
        S_W: begin
          rdata <= load_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - directed self-checking bench for ram_access_ctrl
module tb_ram_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sgn;
  logic [14:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        ack;
  logic [31:0] rdata;
  logic        err;
  logic [12:0] ram_address;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        ram_rnw;
  logic [3:0]  ram_cs_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_access_ctrl #(.AW(15), .DW(32)) dut (
    .clk(clk), .reset_b(reset_b), .req(req), .we(we), .size(size), .sgn(sgn),
    .addr(addr), .wdata(wdata), .busy(busy), .ack(ack), .rdata(rdata), .err(err),
    .ram_address(ram_address), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_rnw(ram_rnw), .ram_cs_b(ram_cs_b)
  );

  // Byte-laned synchronous RAM model
  logic [31:0] mem [8192];
  always @(posedge clk) begin
    if (ram_cs_b != 4'hF) begin
      if (ram_rnw) ram_dout <= mem[ram_address];
      else begin
        for (int b = 0; b < 4; b++)
          if (!ram_cs_b[b]) mem[ram_address][8*b +: 8] <= ram_din[8*b +: 8];
      end
    end
  end

  // Per-cycle observations of the last operation (index 1 = first cycle after accept)
  logic [3:0]  o_cs   [1:8];
  logic [12:0] o_addr [1:8];
  logic [31:0] o_din  [1:8];
  logic        o_rnw  [1:8];
  int          ack_cyc;
  logic        ack_err;

  task automatic do_op(input logic w, input logic [1:0] s, input logic sg,
                       input logic [14:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; size = s; sgn = sg; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    ack_cyc = 0;
    ack_err = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      o_cs[c] = ram_cs_b; o_addr[c] = ram_address; o_din[c] = ram_din; o_rnw[c] = ram_rnw;
      if (ack) begin
        ack_cyc = c;
        ack_err = err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset_b = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (ram_cs_b !== 4'hF) begin bad++; $display("FAIL reset_cs got %h want f", ram_cs_b); end
    total++; if (ram_rnw !== 1'b1) begin bad++; $display("FAIL reset_rnw got %b want 1", ram_rnw); end
    total++; if ({busy, ack, err} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", {busy, ack, err}); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", rdata); end
    total++; if (ram_address !== 13'h0 || ram_din !== 32'h0) begin bad++; $display("FAIL reset_addr_din got %h/%h want 0/0", ram_address, ram_din); end
    reset_b = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || ram_cs_b !== 4'hF) begin bad++; $display("FAIL post_reset got busy=%b cs=%h want 0/f", busy, ram_cs_b); end
  endtask

  task automatic test_aligned_word;
    do_op(1'b1, 2'b10, 1'b0, 15'h0010, 32'hDEADBEEF);
    total++; if (o_addr[1] !== 13'd4 || o_cs[1] !== 4'h0 || o_rnw[1] !== 1'b0) begin bad++; $display("FAIL aw_store_a1 got a=%h cs=%h rnw=%b want 4/0/0", o_addr[1], o_cs[1], o_rnw[1]); end
    total++; if (o_din[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL aw_store_din got %h want deadbeef", o_din[1]); end
    total++; if (ack_cyc !== 2) begin bad++; $display("FAIL aw_store_lat got %0d want 2", ack_cyc); end
    do_op(1'b0, 2'b10, 1'b0, 15'h0010, 32'h0);
    total++; if (o_cs[1] !== 4'h0 || o_rnw[1] !== 1'b1) begin bad++; $display("FAIL aw_load_a1 got cs=%h rnw=%b want 0/1", o_cs[1], o_rnw[1]); end
    total++; if (ack_cyc !== 3) begin bad++; $display("FAIL aw_load_lat got %0d want 3", ack_cyc); end
    total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL aw_load_data got %h want deadbeef", rdata); end
  endtask

  task automatic test_byte;
    do_op(1'b1, 2'b00, 1'b0, 15'h0013, 32'h0000005A);
    total++; if (o_cs[1] !== 4'b0111 || o_din[1][31:24] !== 8'h5A) begin bad++; $display("FAIL byte_store got cs=%b din=%h want 0111/5a", o_cs[1], o_din[1][31:24]); end
    total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rdata_hold got %h want deadbeef", rdata); end
    do_op(1'b0, 2'b00, 1'b1, 15'h0013, 32'h0);
    total++; if (rdata !== 32'h0000005A) begin bad++; $display("FAIL byte_load_pos got %h want 0000005a", rdata); end
    do_op(1'b1, 2'b00, 1'b0, 15'h0013, 32'h00000085);
    do_op(1'b0, 2'b00, 1'b1, 15'h0013, 32'h0);
    total++; if (rdata !== 32'hFFFFFF85) begin bad++; $display("FAIL byte_load_sext got %h want ffffff85", rdata); end
    do_op(1'b0, 2'b00, 1'b0, 15'h0013, 32'h0);
    total++; if (rdata !== 32'h00000085) begin bad++; $display("FAIL byte_load_zext got %h want 00000085", rdata); end
    do_op(1'b0, 2'b01, 1'b1, 15'h0012, 32'h0);
    total++; if (rdata !== 32'hFFFF85AD) begin bad++; $display("FAIL half_load_sext got %h want ffff85ad", rdata); end
  endtask

  task automatic test_back_to_back;
    do_op(1'b1, 2'b10, 1'b0, 15'h0020, 32'h01020304);
    // req during the ack cycle must be ignored
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 15'h0024; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    req = 1'b0;
    total++; if (busy !== 1'b0 || ram_cs_b !== 4'hF) begin bad++; $display("FAIL ack_req_ignored got busy=%b cs=%h want 0/f", busy, ram_cs_b); end
    do_op(1'b0, 2'b10, 1'b0, 15'h0020, 32'h0);
    total++; if (rdata !== 32'h01020304) begin bad++; $display("FAIL b2b_load got %h want 01020304", rdata); end
  endtask

`ifndef RAM_ACCESS_MISALIGN_TRAP_EN
  task automatic test_cross_half;
    do_op(1'b1, 2'b01, 1'b0, 15'h0007, 32'h0000A1B2);
    total++; if (o_addr[1] !== 13'd1 || o_cs[1] !== 4'b0111 || o_din[1][31:24] !== 8'hB2) begin bad++; $display("FAIL xh_a1 got a=%h cs=%b b=%h want 1/0111/b2", o_addr[1], o_cs[1], o_din[1][31:24]); end
    total++; if (o_addr[2] !== 13'd2 || o_cs[2] !== 4'b1110 || o_din[2][7:0] !== 8'hA1) begin bad++; $display("FAIL xh_a2 got a=%h cs=%b b=%h want 2/1110/a1", o_addr[2], o_cs[2], o_din[2][7:0]); end
    total++; if (ack_cyc !== 3 || ack_err !== 1'b0) begin bad++; $display("FAIL xh_store_lat got %0d err=%b want 3/0", ack_cyc, ack_err); end
    do_op(1'b0, 2'b01, 1'b0, 15'h0007, 32'h0);
    total++; if (rdata !== 32'h0000A1B2 || ack_cyc !== 4) begin bad++; $display("FAIL xh_load got %h lat=%0d want 0000a1b2/4", rdata, ack_cyc); end
  endtask

  task automatic test_wrap;
    do_op(1'b1, 2'b10, 1'b0, 15'h7FFC, 32'h11223344);
    do_op(1'b1, 2'b10, 1'b0, 15'h0000, 32'h55667788);
    do_op(1'b0, 2'b10, 1'b0, 15'h7FFE, 32'h0);
    total++; if (o_addr[1] !== 13'd8191 || o_cs[1] !== 4'b0011) begin bad++; $display("FAIL wrap_a1 got a=%0d cs=%b want 8191/0011", o_addr[1], o_cs[1]); end
    total++; if (o_addr[2] !== 13'd0 || o_cs[2] !== 4'b1100) begin bad++; $display("FAIL wrap_a2 got a=%0d cs=%b want 0/1100", o_addr[2], o_cs[2]); end
    total++; if (ack_cyc !== 4) begin bad++; $display("FAIL wrap_lat got %0d want 4", ack_cyc); end
    total++; if (rdata !== 32'h77881122) begin bad++; $display("FAIL wrap_data got %h want 77881122", rdata); end
  endtask

  task automatic test_busy_reset;
    int acks;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b01; sgn = 1'b0; addr = 15'h0007; wdata = 32'h00001234;
    @(negedge clk);
    // A1: a second req must be ignored
    addr = 15'h0100; we = 1'b0;
    total++; if (busy !== 1'b1 || ram_address !== 13'd1) begin bad++; $display("FAIL br_a1 got busy=%b a=%h want 1/1", busy, ram_address); end
    @(negedge clk);
    req = 1'b0;
    total++; if (ram_address !== 13'd2 || ram_cs_b !== 4'b1110 || ram_rnw !== 1'b0) begin bad++; $display("FAIL br_a2 got a=%h cs=%b rnw=%b want 2/1110/0", ram_address, ram_cs_b, ram_rnw); end
    reset_b = 1'b0;
    #1;
    total++; if (ram_cs_b !== 4'hF || busy !== 1'b0 || ack !== 1'b0) begin bad++; $display("FAIL br_async got cs=%h busy=%b ack=%b want f/0/0", ram_cs_b, busy, ack); end
    acks = 0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ack || busy) acks++;
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL br_no_ack got %0d want 0", acks); end
  endtask
`else
  task automatic test_trap;
    logic [31:0] prev;
    logic [3:0]  cs_and;
    prev = rdata;
    do_op(1'b0, 2'b10, 1'b0, 15'h0001, 32'h0);
    cs_and = 4'hF;
    for (int c = 1; c <= ack_cyc; c++) cs_and = cs_and & o_cs[c];
    total++; if (cs_and !== 4'hF) begin bad++; $display("FAIL trap_cs got %h want f", cs_and); end
    total++; if (ack_cyc !== 2 || ack_err !== 1'b1) begin bad++; $display("FAIL trap_ack got lat=%0d err=%b want 2/1", ack_cyc, ack_err); end
    total++; if (rdata !== prev) begin bad++; $display("FAIL trap_rdata got %h want %h", rdata, prev); end
  endtask
`endif

  initial begin
    reset_b = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sgn = 1'b0; addr = '0; wdata = '0;
    test_reset;
    test_aligned_word;
    test_byte;
    test_back_to_back;
`ifndef RAM_ACCESS_MISALIGN_TRAP_EN
    test_cross_half;
    test_wrap;
    test_busy_reset;
`else
    test_trap;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Initiator side of the 8192x32 byte-laned synchronous RAM port: the load/store engine that drives address, rnw, active-low byte chip-selects and write data, then collects read data one cycle later.
- Accepts byte, halfword and word requests from the CPU datapath at byte granularity.
- Splits accesses that cross a word boundary into two RAM cycles and merges the read data.
- Applies sign or zero extension on loads.

Parameters:
- AW, 15, byte address width. The RAM word address is AW-2 = 13 bits.
- DW, 32, data width. Fixed at 32; other values are unsupported.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- req  in  1  one-cycle request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = treated as word.
- sgn  in  1  load sign-extend enable.
- addr  in  AW  byte address.
- wdata  in  32  store data, right-justified.
- busy  out  1  high from the accept edge until the ack cycle inclusive.
- ack  out  1  one-cycle completion pulse.
- rdata  out  32  load result; valid in the ack cycle and held until the next load ack.
- err  out  1  misalign trap pulse, coincident with ack (see Optional Feature).
- ram_address  out  13  RAM word address.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data; valid the cycle after the RAM's read edge.
- ram_rnw  out  1  1 = read, 0 = write.
- ram_cs_b  out  4  active-low byte selects; bit n selects bits [8n+7:8n].

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; busy = 0, ack = 0, err = 0, rdata = 0.
  - ram_cs_b = 4'hF, ram_rnw = 1, ram_address = 0, ram_din = 0.
- All RAM-side outputs are registered. Outside active cycles ram_cs_b = 4'hF and ram_rnw = 1.
- Accept: at an edge with state == IDLE and req == 1, capture we/size/sgn/addr/wdata. A req outside IDLE is ignored with no error.
- Decode:
  - off = addr[1:0]; n = 1/2/4 bytes; wa = addr[AW-1:2].
  - cross = (off + n > 4).
  - Lanes are little-endian: byte at off lands on lane off.
- Access 1: ram_address = wa; lanes off..min(3, off+n-1) have cs_b = 0, the rest 1.
- Access 2 (cross only): ram_address = wa + 1, modulo 8192 (8191 wraps to 0); lanes 0..(off+n-5) active.
- Store data: ram_din = {wdata, wdata} rotated left by 8*off. The same value is driven for both accesses.
- States and transitions:
  - IDLE -> A1 on accept.
  - A1 -> A2 if cross, else W (load) or DONE (store).
  - A2 -> W (load) or DONE (store).
  - W -> DONE, and is a single cycle.
  - DONE -> IDLE.
- RAM outputs are valid during the A1/A2 cycles. The RAM samples them on the edge that exits the state.
- Read capture: the load word for A1 is captured at the edge leaving the following state; for A2 likewise. Reads are pipelined: A1, A2, W.
- Load merge:
  - m = {word2, word1} >> (8*off).
  - Take the low 8*n bits. If sgn, sign-extend from bit 8n-1; otherwise zero-extend.
  - For a word, sgn has no effect.
- ack is high for the single DONE cycle. busy is low only in IDLE.
- Cycles from the accept edge to the ack cycle:
  - aligned store 2;
  - crossing store 3;
  - aligned load 3;
  - crossing load 4.
- A new req in the ack cycle is ignored. A req in the cycle after ack is accepted.
- Reset mid-operation: immediately returns to the reset values. Any RAM write already sampled stands; no partial rollback.

Optional Feature:
- Macro: RAM_ACCESS_MISALIGN_TRAP_EN.
- Defined:
  - An accepted request with cross == 1 issues no RAM cycle (cs_b stays 4'hF).
  - The controller goes A1 -> DONE with err = 1 and ack = 1 in the same cycle; rdata is unchanged.
  - Non-crossing requests behave as normal.
- Undefined: crossing accesses are split as described above; err is constant 0.

Test Plan:
- Aligned word store addr = 0x0010, wdata = 0xDEADBEEF, then load same address -> ram_address = 4 with cs_b = 4'h0 on the store; load ack 3 cycles after accept with rdata = 0xDEADBEEF.
- Byte store 0x5A at addr = 0x0013, then signed byte load -> store drives cs_b = 4'b0111 and ram_din[31:24] = 0x5A; load gives rdata = 0x0000005A; storing 0x85 then loading with sgn = 1 gives 0xFFFFFF85.
- Crossing halfword store 0xA1B2 at addr = 0x0007 -> access 1 to word 1 with cs_b = 4'b0111 and byte 0xB2; access 2 to word 2 with cs_b = 4'b1110 and byte 0xA1; ack 3 cycles after accept; the matching load returns 0x0000A1B2.
- Crossing word load at addr = 0x7FFE (word 8191 -> 0) with words 0x11223344 and 0x55667788 -> second ram_address = 0; rdata = 0x77881122; ack 4 cycles after accept.
- req pulsed while busy, plus reset_b asserted during A2 of a crossing store -> the extra req is ignored; after reset, cs_b = 4'hF and busy = 0 immediately, and no ack is produced.
- With RAM_ACCESS_MISALIGN_TRAP_EN defined, word load at addr = 0x0001 -> no cs_b activity, err = 1 and ack = 1 in the same cycle, rdata unchanged.
